loop_addr_gen: RTL

Three-level nested-loop address generator. Each loop index follows wrap-on-limit counter semantics: the index advances by a step and returns to zero when it would reach its limit. The block streams one address per valid/ready beat to a downstream SRAM/feeder port. It sits upstream of the memory-side consumers and replaces ad-hoc chains of independent loop counters with one handshaked, back-pressurable sequencer.

---
 rtl/loop_addr_gen.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/loop_addr_gen.sv
// loop_addr_gen: three-level nested-loop address generator.
// Streams one address per valid/ready beat. Each loop index advances by its
// step and wraps to zero when it would reach its limit. The y and z strides
// are accumulated incrementally, so no multipliers are needed.
module loop_addr_gen #(
    parameter int CNT_W = 8,
    parameter int ADR_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_clear,
    input  logic [CNT_W-1:0] i_lim_x,
    input  logic [CNT_W-1:0] i_lim_y,
    input  logic [CNT_W-1:0] i_lim_z,
    input  logic [CNT_W-1:0] i_step_x,
    input  logic [CNT_W-1:0] i_step_y,
    input  logic [CNT_W-1:0] i_step_z,
    input  logic [ADR_W-1:0] i_base,
    input  logic [ADR_W-1:0] i_stride_y,
    input  logic [ADR_W-1:0] i_stride_z,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [ADR_W-1:0] o_addr,
    output logic [CNT_W-1:0] o_idx_x,
    output logic [CNT_W-1:0] o_idx_y,
    output logic [CNT_W-1:0] o_idx_z,
    output logic             o_last,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    // Latched configuration; zero limits and steps are stored as one so the
    // loop logic never has to special-case them.
    logic [CNT_W-1:0] lim_x, lim_y, lim_z;
    logic [CNT_W-1:0] step_x, step_y, step_z;
    logic [ADR_W-1:0] base, stride_y, stride_z;

    logic [CNT_W-1:0] idx_x, idx_y, idx_z;
    logic [ADR_W-1:0] acc_y, acc_z;
    logic             valid_q, busy_q, done_q;

    // Next-index sums are one bit wider than the index so large steps
    // cannot overflow and falsely look smaller than the limit.
    logic [CNT_W:0] nx, ny, nz;
    logic           wrap_x, wrap_y, wrap_z;
    logic           wrap_all;
    logic           beat;

    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    // Wrap detection for each loop level, derived only from registered state.
    always_comb begin
        nx       = {1'b0, idx_x} + {1'b0, step_x};
        ny       = {1'b0, idx_y} + {1'b0, step_y};
        nz       = {1'b0, idx_z} + {1'b0, step_z};
        wrap_x   = (nx >= {1'b0, lim_x});
        wrap_y   = (ny >= {1'b0, lim_y});
        wrap_z   = (nz >= {1'b0, lim_z});
        wrap_all = wrap_x && wrap_y && wrap_z;
        beat     = valid_q && i_ready;
    end

    // Sequencer FSM plus index and accumulator updates on each accepted beat.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            lim_x    <= '0;
            lim_y    <= '0;
            lim_z    <= '0;
            step_x   <= '0;
            step_y   <= '0;
            step_z   <= '0;
            base     <= '0;
            stride_y <= '0;
            stride_z <= '0;
            idx_x    <= '0;
            idx_y    <= '0;
            idx_z    <= '0;
            acc_y    <= '0;
            acc_z    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (i_clear) begin
            state    <= IDLE;
            idx_x    <= '0;
            idx_y    <= '0;
            idx_z    <= '0;
            acc_y    <= '0;
            acc_z    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (i_start) begin
                        lim_x    <= at_least_one(i_lim_x);
                        lim_y    <= at_least_one(i_lim_y);
                        lim_z    <= at_least_one(i_lim_z);
                        step_x   <= at_least_one(i_step_x);
                        step_y   <= at_least_one(i_step_y);
                        step_z   <= at_least_one(i_step_z);
                        base     <= i_base;
                        stride_y <= i_stride_y;
                        stride_z <= i_stride_z;
                        idx_x    <= '0;
                        idx_y    <= '0;
                        idx_z    <= '0;
                        acc_y    <= '0;
                        acc_z    <= '0;
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (beat) begin
                        if (wrap_all) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state   <= DONE;
                        end
                        if (!wrap_x) begin
                            idx_x <= nx[CNT_W-1:0];
                        end else begin
                            idx_x <= '0;
                            if (!wrap_y) begin
                                idx_y <= ny[CNT_W-1:0];
                                acc_y <= acc_y + stride_y;
                            end else begin
                                idx_y <= '0;
                                acc_y <= '0;
                                if (!wrap_z) begin
                                    idx_z <= nz[CNT_W-1:0];
                                    acc_z <= acc_z + stride_z;
                                end else begin
                                    idx_z <= '0;
                                    acc_z <= '0;
                                end
                            end
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs are registered or built purely from registered terms, so
    // i_ready never reaches o_addr combinationally.
    always_comb begin
        o_addr  = base + ADR_W'(idx_x) + acc_y + acc_z;
        o_idx_x = idx_x;
        o_idx_y = idx_y;
        o_idx_z = idx_z;
        o_valid = valid_q;
        o_last  = valid_q && wrap_all;
        o_busy  = busy_q;
        o_done  = done_q;
    end

endmodule
